ls_queue: RTL and testbench
===========================

# ls_queue

In-order load/store issue queue that sits directly upstream of the AGU/data-memory stage in the Tomasulo back-end. It accepts dispatched memory instructions, snoops the CDB until base and store-data operands are ready, and issues the head entry to the AGU with a computed effective address, store data, load/store flag and destination tag. Loads and stores leave the queue strictly in program order.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- TAG_W, 6: ROB/rename tag width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals !full.
- disp_ls  in  1  0 = load, 1 = store.
- disp_rs1_data / disp_rs1_tag / disp_rs1_valid  in  32/TAG_W/1  base operand; valid=1 means data is final.
- disp_rs2_data / disp_rs2_tag / disp_rs2_valid  in  32/TAG_W/1  store data operand (ignored for loads).
- disp_imm  in  32  sign-extended offset.
- disp_rd_tag  in  TAG_W  destination tag (loads).
- cdb_valid / cdb_tag / cdb_data  in  1/TAG_W/32  common data bus broadcast.
- agu_ready  in  1  AGU can accept this cycle.
- agu_issue  out  1  head issued this cycle.
- addr  out  32  rs1 + imm, modulo 2^32.
- data_in  out  32  store data.
- ls  out  1  head load/store flag.
- tag_in  out  TAG_W  head destination tag.
- tag_in_valid  out  1  agu_issue & !ls.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping naturally, separate occupancy counter.
- Push: disp_valid & disp_ready writes entry at tail, tail+1, count+1.
- Entry readiness: valid & rs1_valid & (!ls | rs2_valid).
- CDB snoop: every cycle each valid entry with operand valid=0 and tag==cdb_tag while cdb_valid captures cdb_data and sets valid=1. Both operands of one entry may match the same broadcast.
- Dispatch bypass: if a dispatched operand has valid=0 and its tag matches the CDB that same cycle, the entry is written with the CDB data and valid=1.
- Issue: agu_issue = head ready & agu_ready & !flush; pops head at clock edge. Only the head is ever examined (no out-of-order issue, no load bypass of stores).
- Outputs addr, data_in, ls, tag_in are combinational from head entry regardless of agu_issue; when empty they are driven from the zeroed head slot.
- Push and pop in the same cycle: count unchanged. When full, disp_ready=0 even if a pop occurs that cycle (no same-cycle refill).
- flush: all entries invalidated, pointers and count to 0 at next edge; a dispatch in the flush cycle is discarded; agu_issue forced 0.

## Timing
- Reset (async assert, sync-released use): all entries invalid and zeroed, head=tail=0, count=0, disp_ready=1, agu_issue=0, addr=0, data_in=0, ls=0, tag_in=0, tag_in_valid=0.
- Dispatch-to-issue minimum latency 1 cycle: entry written at edge N with operands ready may issue in cycle N+1.
- CDB wakeup latency: broadcast at cycle N, entry issues at earliest N+1.
- agu_issue has no registered stage; AGU samples outputs in the same cycle.
- Reset mid-operation discards all contents immediately.

## Structure
- Shared package cpu_pkg: TAG_W, tag_t, ls_e (LOAD=0, STORE=1), lsq_entry_t struct {valid, ls, rs1_data, rs1_tag, rs1_valid, rs2_data, rs2_tag, rs2_valid, imm, rd_tag}.
- One sub-module natural: lsq_operand_snoop (per-operand CDB compare/capture, instantiated 2×DEPTH plus dispatch bypass).

## Test plan
- Reset then load rs1=0x1000 valid, imm=0x10, rd_tag=5, agu_ready=1 -> next cycle agu_issue=1, addr=0x1010, ls=0, tag_in=5, tag_in_valid=1.
- Store rs1 valid 0x2000, rs2 tag 9 invalid -> no issue; CDB tag 9 data 0xDEADBEEF -> next cycle agu_issue=1, data_in=0xDEADBEEF, tag_in_valid=0.
- Store head blocked on rs2, ready load behind it -> load does not issue until store issues (order preserved).
- Fill 4 entries with agu_ready=0 -> disp_ready=0, count=4; pop while disp_valid=1 -> no push that cycle; 8 total pushes/pops verify pointer wrap.
- Dispatch with rs1 tag 3 invalid while CDB broadcasts tag 3 data 0x40 -> entry captured ready, issues next cycle with addr=0x40+imm; imm=0xFFFFFFFC, rs1=0x2 -> addr=0xFFFFFFFE.
- flush with 3 entries and concurrent dispatch -> count=0, agu_issue=0 next cycle; rst_n pulse mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared back-end types: rename tags, load/store flag and the load/store queue entry.
package cpu_pkg;

   localparam int TAG_W = 6;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } ls_e;

   typedef struct packed {
      logic        valid;
      ls_e         ls;
      logic [31:0] rs1_data;
      tag_t        rs1_tag;
      logic        rs1_valid;
      logic [31:0] rs2_data;
      tag_t        rs2_tag;
      logic        rs2_valid;
      logic [31:0] imm;
      tag_t        rd_tag;
   } lsq_entry_t;

endpackage

// File: rtl/lsq_operand_snoop.sv
// One operand's CDB wakeup: a pending operand whose tag matches the broadcast
// takes the broadcast data and becomes final.
module lsq_operand_snoop
   import cpu_pkg::*;
(
   input  logic        op_valid,
   input  tag_t        op_tag,
   input  logic [31:0] op_data,
   input  logic        cdb_valid,
   input  tag_t        cdb_tag,
   input  logic [31:0] cdb_data,
   output logic        out_valid,
   output logic [31:0] out_data
);

   logic hit;

   assign hit       = cdb_valid & ~op_valid & (op_tag == cdb_tag);
   assign out_valid = op_valid | hit;
   assign out_data  = hit ? cdb_data : op_data;

endmodule

// File: rtl/ls_queue.sv
// In-order load/store issue queue: holds dispatched memory ops, wakes operands
// from the CDB and hands the head entry to the AGU strictly in program order.
module ls_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic                       disp_ls,
   input  logic [31:0]                disp_rs1_data,
   input  logic [TAG_W-1:0]           disp_rs1_tag,
   input  logic                       disp_rs1_valid,
   input  logic [31:0]                disp_rs2_data,
   input  logic [TAG_W-1:0]           disp_rs2_tag,
   input  logic                       disp_rs2_valid,
   input  logic [31:0]                disp_imm,
   input  logic [TAG_W-1:0]           disp_rd_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [31:0]                cdb_data,
   input  logic                       agu_ready,
   output logic                       agu_issue,
   output logic [31:0]                addr,
   output logic [31:0]                data_in,
   output logic                       ls,
   output logic [TAG_W-1:0]           tag_in,
   output logic                       tag_in_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   lsq_entry_t     q [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  cnt;

   logic           s1_v [DEPTH];
   logic [31:0]    s1_d [DEPTH];
   logic           s2_v [DEPTH];
   logic [31:0]    s2_d [DEPTH];

   logic           byp1_v, byp2_v;
   logic [31:0]    byp1_d, byp2_d;

   tag_t           cdb_t;
   lsq_entry_t     disp_entry;
   lsq_entry_t     hd;
   logic           full, head_ready, do_push, do_pop;

   assign cdb_t = tag_t'(cdb_tag);

   for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
      lsq_operand_snoop u_rs1 (
         .op_valid  (q[i].rs1_valid),
         .op_tag    (q[i].rs1_tag),
         .op_data   (q[i].rs1_data),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_t),
         .cdb_data  (cdb_data),
         .out_valid (s1_v[i]),
         .out_data  (s1_d[i])
      );
      lsq_operand_snoop u_rs2 (
         .op_valid  (q[i].rs2_valid),
         .op_tag    (q[i].rs2_tag),
         .op_data   (q[i].rs2_data),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_t),
         .cdb_data  (cdb_data),
         .out_valid (s2_v[i]),
         .out_data  (s2_d[i])
      );
   end

   // Dispatch bypass: an operand broadcast in the dispatch cycle is written already final.
   lsq_operand_snoop u_byp_rs1 (
      .op_valid  (disp_rs1_valid),
      .op_tag    (tag_t'(disp_rs1_tag)),
      .op_data   (disp_rs1_data),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_t),
      .cdb_data  (cdb_data),
      .out_valid (byp1_v),
      .out_data  (byp1_d)
   );

   lsq_operand_snoop u_byp_rs2 (
      .op_valid  (disp_rs2_valid),
      .op_tag    (tag_t'(disp_rs2_tag)),
      .op_data   (disp_rs2_data),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_t),
      .cdb_data  (cdb_data),
      .out_valid (byp2_v),
      .out_data  (byp2_d)
   );

   always_comb begin
      disp_entry           = '0;
      disp_entry.valid     = 1'b1;
      disp_entry.ls        = ls_e'(disp_ls);
      disp_entry.rs1_data  = byp1_d;
      disp_entry.rs1_tag   = tag_t'(disp_rs1_tag);
      disp_entry.rs1_valid = byp1_v;
      disp_entry.rs2_data  = byp2_d;
      disp_entry.rs2_tag   = tag_t'(disp_rs2_tag);
      disp_entry.rs2_valid = byp2_v;
      disp_entry.imm       = disp_imm;
      disp_entry.rd_tag    = tag_t'(disp_rd_tag);
   end

   // Handshakes: a dispatch transfers on a clock edge where disp_valid & disp_ready
   // (and no flush); the head transfers to the AGU on an edge where agu_issue is high,
   // which already includes agu_ready. disp_ready never depends on disp_valid.
   assign hd         = q[head];
   assign full       = (cnt == CW'(DEPTH));
   assign disp_ready = ~full;
   assign head_ready = hd.valid & hd.rs1_valid & ((hd.ls == LOAD) | hd.rs2_valid);
   assign agu_issue  = head_ready & agu_ready & ~flush;
   assign do_push    = disp_valid & disp_ready & ~flush;
   assign do_pop     = agu_issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) begin
               q[i].rs1_valid <= s1_v[i];
               q[i].rs1_data  <= s1_d[i];
               q[i].rs2_valid <= s2_v[i];
               q[i].rs2_data  <= s2_d[i];
            end
         end
         // Popped slots are zeroed so an empty queue presents all-zero outputs.
         if (do_pop) begin
            q[head] <= '0;
            head    <= head + PW'(1);
         end
         if (do_push) begin
            q[tail] <= disp_entry;
            tail    <= tail + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign addr         = hd.rs1_data + hd.imm;
   assign data_in      = hd.rs2_data;
   assign ls           = (hd.ls == STORE);
   assign tag_in       = TAG_W'(hd.rd_tag);
   assign tag_in_valid = agu_issue & (hd.ls == LOAD);
   assign count        = cnt;

endmodule

// File: tb/tb_ls_queue.sv
// Bench for ls_queue: issue results are checked against an expected queue filled at dispatch.
module tb_ls_queue;

   logic        clk, rst_n, flush;
   logic        disp_valid, disp_ready, disp_ls;
   logic [31:0] disp_rs1_data, disp_rs2_data, disp_imm;
   logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
   logic        disp_rs1_valid, disp_rs2_valid;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        agu_ready, agu_issue;
   logic [31:0] addr, data_in;
   logic        ls;
   logic [5:0]  tag_in;
   logic        tag_in_valid;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   // {addr[71:40], data_in[39:8], ls[7], tag_in[6:1], tag_in_valid[0]}
   logic [71:0] exp_q[$];

   typedef struct {
      logic        ls;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [5:0]  rd;
      logic [31:0] e_addr;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [6];

   ls_queue #(.DEPTH(4), .TAG_W(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_ls        (disp_ls),
      .disp_rs1_data  (disp_rs1_data),
      .disp_rs1_tag   (disp_rs1_tag),
      .disp_rs1_valid (disp_rs1_valid),
      .disp_rs2_data  (disp_rs2_data),
      .disp_rs2_tag   (disp_rs2_tag),
      .disp_rs2_valid (disp_rs2_valid),
      .disp_imm       (disp_imm),
      .disp_rd_tag    (disp_rd_tag),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .agu_ready      (agu_ready),
      .agu_issue      (agu_issue),
      .addr           (addr),
      .data_in        (data_in),
      .ls             (ls),
      .tag_in         (tag_in),
      .tag_in_valid   (tag_in_valid),
      .count          (count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] mk_exp(input logic [31:0] a, input logic [31:0] d,
                                          input logic l, input logic [5:0] t);
      return {a, d, l, t, ~l};
   endfunction

   // drivers
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_disp(input logic l, input logic [31:0] r1d, input logic [5:0] r1t,
                             input logic r1v, input logic [31:0] r2d, input logic [5:0] r2t,
                             input logic r2v, input logic [31:0] im, input logic [5:0] rd);
      disp_valid     = 1'b1;
      disp_ls        = l;
      disp_rs1_data  = r1d;
      disp_rs1_tag   = r1t;
      disp_rs1_valid = r1v;
      disp_rs2_data  = r2d;
      disp_rs2_tag   = r2t;
      disp_rs2_valid = r2v;
      disp_imm       = im;
      disp_rd_tag    = rd;
   endtask

   task automatic idle_disp();
      disp_valid = 1'b0;
   endtask

   task automatic bcast(input logic [5:0] t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_ready"}, disp_ready, 1);
      check({name, "_issue"}, agu_issue, 0);
      check({name, "_addr"}, addr, 0);
      check({name, "_data"}, data_in, 0);
      check({name, "_ls"}, ls, 0);
      check({name, "_tag"}, tag_in, 0);
      check({name, "_tagv"}, tag_in_valid, 0);
      check({name, "_count"}, count, 0);
   endtask

   // scoreboard: every issue must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && agu_issue) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", agu_issue, 0);
         end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            check("issue_addr", addr, e[71:40]);
            check("issue_data", data_in, e[39:8]);
            check("issue_ls", ls, e[7]);
            check("issue_tag", tag_in, e[6:1]);
            check("issue_tagv", tag_in_valid, e[0]);
         end
      end
   end

   initial begin
      vecs[0] = '{ls: 1'b0, rs1: 32'h0000_1000, rs2: 32'h0, imm: 32'h0000_0010, rd: 6'd4,
                  e_addr: 32'h0000_1010, e_data: 32'h0};
      vecs[1] = '{ls: 1'b0, rs1: 32'h0000_0002, rs2: 32'h0, imm: 32'hFFFF_FFFC, rd: 6'd1,
                  e_addr: 32'hFFFF_FFFE, e_data: 32'h0};
      vecs[2] = '{ls: 1'b1, rs1: 32'h8000_0000, rs2: 32'h1234_5678, imm: 32'h7FFF_FFFF, rd: 6'd2,
                  e_addr: 32'hFFFF_FFFF, e_data: 32'h1234_5678};
      vecs[3] = '{ls: 1'b1, rs1: 32'hFFFF_FFFF, rs2: 32'hA5A5_A5A5, imm: 32'h0000_0001, rd: 6'd63,
                  e_addr: 32'h0000_0000, e_data: 32'hA5A5_A5A5};
      vecs[4] = '{ls: 1'b0, rs1: 32'hCAFE_0000, rs2: 32'h0, imm: 32'h0000_BEEF, rd: 6'd33,
                  e_addr: 32'hCAFE_BEEF, e_data: 32'h0};
      vecs[5] = '{ls: 1'b1, rs1: 32'h0000_0010, rs2: 32'h0, imm: 32'hFFFF_FFF0, rd: 6'd0,
                  e_addr: 32'h0000_0000, e_data: 32'h0};

      rst_n = 1'b0; flush = 1'b0; agu_ready = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      drive_disp(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0);
      idle_disp();
      #3;
      check_idle_outputs("reset");
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // single ready load: issues the cycle after dispatch
      agu_ready = 1'b1;
      drive_disp(1'b0, 32'h0000_1000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 32'h0000_0010, 6'd5);
      exp_q.push_back(mk_exp(32'h0000_1010, 32'h0, 1'b0, 6'd5));
      @(negedge clk);
      check("t1_no_issue_same_cycle", agu_issue, 0);
      cyc();
      idle_disp();
      @(negedge clk);
      check("t1_issue", agu_issue, 1);
      cyc();
      wait_drain("t1_drain");

      // table vectors, back to back
      for (int k = 0; k < 6; k++) begin
         drive_disp(vecs[k].ls, vecs[k].rs1, 6'd0, 1'b1, vecs[k].rs2, 6'd0, 1'b1,
                    vecs[k].imm, vecs[k].rd);
         exp_q.push_back(mk_exp(vecs[k].e_addr, vecs[k].e_data, vecs[k].ls, vecs[k].rd));
         cyc();
      end
      idle_disp();
      wait_drain("table_drain");

      // store waiting on rs2, woken by CDB
      drive_disp(1'b1, 32'h0000_2000, 6'd0, 1'b1, 32'h0, 6'd9, 1'b0, 32'h0, 6'd7);
      exp_q.push_back(mk_exp(32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 6'd7));
      cyc();
      idle_disp();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t2_blocked", agu_issue, 0);
         cyc();
      end
      bcast(6'd9, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t2_wake_latency", agu_issue, 0);
      cyc();
      cdb_valid = 1'b0;
      @(negedge clk);
      check("t2_issue", agu_issue, 1);
      cyc();
      wait_drain("t2_drain");

      // both operands of one queued store woken by one broadcast
      drive_disp(1'b1, 32'h0, 6'd11, 1'b0, 32'h0, 6'd11, 1'b0, 32'h0000_0004, 6'd6);
      exp_q.push_back(mk_exp(32'h0000_0704, 32'h0000_0700, 1'b1, 6'd6));
      cyc();
      idle_disp();
      cyc();
      bcast(6'd11, 32'h0000_0700);
      cyc();
      cdb_valid = 1'b0;
      wait_drain("t2b_drain");

      // blocked store at head holds back a ready load
      drive_disp(1'b1, 32'h0000_0100, 6'd0, 1'b1, 32'h0, 6'd12, 1'b0, 32'h0, 6'd13);
      exp_q.push_back(mk_exp(32'h0000_0100, 32'h0000_0055, 1'b1, 6'd13));
      cyc();
      drive_disp(1'b0, 32'h0000_3000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 32'h0000_0004, 6'd8);
      exp_q.push_back(mk_exp(32'h0000_3004, 32'h0, 1'b0, 6'd8));
      cyc();
      idle_disp();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t3_order_hold", agu_issue, 0);
         cyc();
      end
      check("t3_count", count, 2);
      bcast(6'd12, 32'h0000_0055);
      cyc();
      cdb_valid = 1'b0;
      wait_drain("t3_drain");

      // fill, no same-cycle refill when full, pointer wrap
      agu_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_disp(1'b0, 32'h100 * k, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, k, 6'(20 + k));
         exp_q.push_back(mk_exp(32'h100 * k + k, 32'h0, 1'b0, 6'(20 + k)));
         cyc();
      end
      idle_disp();
      check("t4_full_ready", disp_ready, 0);
      check("t4_full_count", count, 4);
      agu_ready = 1'b1;
      drive_disp(1'b0, 32'h0000_9999, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 32'h0, 6'd50);
      @(negedge clk);
      check("t4_pop_ready", disp_ready, 0);
      check("t4_pop_issue", agu_issue, 1);
      cyc();
      idle_disp();
      agu_ready = 1'b0;
      @(negedge clk);
      check("t4_no_refill_count", count, 3);
      cyc();
      agu_ready = 1'b1;
      for (int k = 4; k < 8; k++) begin
         drive_disp(1'b0, 32'h100 * k, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, k, 6'(20 + k));
         exp_q.push_back(mk_exp(32'h100 * k + k, 32'h0, 1'b0, 6'(20 + k)));
         cyc();
      end
      idle_disp();
      wait_drain("t4_drain");
      check("t4_empty_count", count, 0);

      // dispatch bypass, single operand and both operands
      drive_disp(1'b0, 32'h0000_0999, 6'd3, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0000_0008, 6'd10);
      bcast(6'd3, 32'h0000_0040);
      exp_q.push_back(mk_exp(32'h0000_0048, 32'h0, 1'b0, 6'd10));
      cyc();
      idle_disp();
      cdb_valid = 1'b0;
      @(negedge clk);
      check("t5_bypass_issue", agu_issue, 1);
      cyc();
      drive_disp(1'b1, 32'h0, 6'd4, 1'b0, 32'h0, 6'd4, 1'b0, 32'h0, 6'd14);
      bcast(6'd4, 32'h0000_0080);
      exp_q.push_back(mk_exp(32'h0000_0080, 32'h0000_0080, 1'b1, 6'd14));
      cyc();
      idle_disp();
      cdb_valid = 1'b0;
      @(negedge clk);
      check("t5_bypass2_issue", agu_issue, 1);
      cyc();
      wait_drain("t5_drain");

      // flush with 3 entries and a concurrent dispatch
      agu_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_disp(1'b0, 32'h0000_4000, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, k, 6'(40 + k));
         cyc();
      end
      check("t6_pre_count", count, 3);
      agu_ready = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check("t6_flush_issue", agu_issue, 0);
      cyc();
      flush = 1'b0;
      idle_disp();
      check_idle_outputs("t6_post");

      // asynchronous reset mid-stream
      agu_ready = 1'b0;
      drive_disp(1'b1, 32'h0000_0500, 6'd0, 1'b1, 32'h0000_0600, 6'd0, 1'b1, 32'h0, 6'd3);
      cyc();
      drive_disp(1'b0, 32'h0000_0700, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 32'h0, 6'd2);
      cyc();
      idle_disp();
      check("t7_head_addr", addr, 32'h0000_0500);
      check("t7_head_data", data_in, 32'h0000_0600);
      check("t7_head_ls", ls, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t7_rst");
      cyc();
      rst_n = 1'b1;
      cyc();
      check("final_exp_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
